mips_lsu: RTL

//  Parametrised load/store unit between the pipeline MEM stage and a wait-state data bus.

---
 rtl/mips_lsu.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/mips_lsu.sv
// rtl/mips_lsu.sv - MEM-stage load/store unit driving a req/addr_ok/data_ok wait-state bus
// Optional: MIPS_LSU_ALIGN_EXC_EN raises adel/ades on misaligned accesses instead of forcing alignment.
module mips_lsu #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  memen_M,
   input  logic                  memwrite_M,
   input  logic [1:0]            membyte_M,
   input  logic                  memsignext_M,
   input  logic [ADDR_W-1:0]     addr_M,
   input  logic [DATA_W-1:0]     wdata_M,
   input  logic                  flush_M,
   output logic                  stall_M,
   output logic                  done_M,
   output logic [DATA_W-1:0]     rdata_W,
   output logic                  bus_err,
   output logic                  adel,
   output logic                  ades,
   output logic                  req,
   output logic                  wr,
   output logic [ADDR_W-1:0]     baddr,
   output logic [DATA_W/8-1:0]   bwen,
   output logic [DATA_W-1:0]     bwdata,
   input  logic                  addr_ok,
   input  logic                  data_ok,
   input  logic [DATA_W-1:0]     brdata
);
   localparam int BYTES = DATA_W / 8;
   localparam int LB    = $clog2(BYTES);
   localparam int CW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN, DONE} state_t;

   state_t            state;
   logic [CW-1:0]     cnt;
   logic [1:0]        size, size_q;
   logic [LB-1:0]     lane_raw, lane, lane_q;
   logic              sx_q;
   logic              misal;
   logic              timeout_hit;
   logic [BYTES-1:0]  bwen_c;
   logic [DATA_W-1:0] bwdata_c, shifted, ld;

   // A dword request on a 32-bit bus degrades to a word access
   assign size     = (membyte_M == 2'b11 && DATA_W == 32) ? 2'b10 : membyte_M;
   assign lane_raw = addr_M[LB-1:0];

`ifdef MIPS_LSU_ALIGN_EXC_EN
   assign misal = (size == 2'b01 && lane_raw[0]) ||
                  (size == 2'b10 && lane_raw[1:0] != 2'b00) ||
                  (size == 2'b11 && lane_raw != '0);
`else
   assign misal = 1'b0;
`endif

   always_comb begin
      lane = lane_raw;
      case (size)
         2'b01:   lane = lane_raw & ~LB'(1);
         2'b10:   lane = lane_raw & ~LB'(3);
         2'b11:   lane = '0;
         default: lane = lane_raw;
      endcase
   end

   always_comb begin
      bwen_c   = '1;
      bwdata_c = wdata_M;
      case (size)
         2'b00: begin
            bwen_c   = BYTES'(1) << lane;
            bwdata_c = {BYTES{wdata_M[7:0]}};
         end
         2'b01: begin
            bwen_c   = BYTES'(3) << lane;
            bwdata_c = {(BYTES/2){wdata_M[15:0]}};
         end
         2'b10: begin
            bwen_c   = BYTES'(4'hF) << lane;
            bwdata_c = {(DATA_W/32){wdata_M[31:0]}};
         end
         default: begin
            bwen_c   = '1;
            bwdata_c = wdata_M;
         end
      endcase
   end

   function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] v, input int nbits,
                                                input logic sx);
      logic [DATA_W-1:0] r;
      for (int i = 0; i < DATA_W; i++)
         r[i] = (i < nbits) ? v[i] : (sx & v[nbits-1]);
      return r;
   endfunction

   assign shifted = brdata >> {lane_q, 3'b000};

   always_comb begin
      case (size_q)
         2'b00:   ld = extend(shifted, 8, sx_q);
         2'b01:   ld = extend(shifted, 16, sx_q);
         2'b10:   ld = extend(shifted, 32, sx_q);
         default: ld = shifted;
      endcase
   end

   assign timeout_hit = (TIMEOUT > 0) && (cnt == CW'(TIMEOUT - 1));
   assign stall_M     = (memen_M && state != DONE) || state == DRAIN;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         cnt     <= '0;
         size_q  <= 2'b00;
         lane_q  <= '0;
         sx_q    <= 1'b0;
         req     <= 1'b0;
         wr      <= 1'b0;
         baddr   <= '0;
         bwen    <= '0;
         bwdata  <= '0;
         rdata_W <= '0;
         done_M  <= 1'b0;
         bus_err <= 1'b0;
         adel    <= 1'b0;
         ades    <= 1'b0;
      end else begin
         done_M  <= 1'b0;
         bus_err <= 1'b0;
         adel    <= 1'b0;
         ades    <= 1'b0;
         case (state)
            IDLE: if (memen_M && !flush_M) begin
               wr     <= memwrite_M;
               baddr  <= {addr_M[ADDR_W-1:LB], LB'(0)};
               bwdata <= bwdata_c;
               size_q <= size;
               lane_q <= lane;
               sx_q   <= memsignext_M;
               cnt    <= '0;
               if (misal) begin
                  bwen   <= '0;
                  done_M <= 1'b1;
                  adel   <= !memwrite_M;
                  ades   <= memwrite_M;
                  state  <= DONE;
               end else begin
                  bwen  <= memwrite_M ? bwen_c : '0;
                  req   <= 1'b1;
                  state <= REQ;
               end
            end
            REQ: if (addr_ok) begin
               req <= 1'b0;
               // An accepted-then-flushed request still owes a data_ok that must be swallowed
               if (flush_M) state <= data_ok ? IDLE : DRAIN;
               else if (data_ok) begin
                  if (!wr) rdata_W <= ld;
                  done_M <= 1'b1;
                  state  <= DONE;
               end else state <= WAIT;
            end else if (flush_M) begin
               req   <= 1'b0;
               state <= IDLE;
            end
            WAIT: begin
               if (flush_M) state <= data_ok ? IDLE : DRAIN;
               else if (data_ok) begin
                  if (!wr) rdata_W <= ld;
                  done_M <= 1'b1;
                  state  <= DONE;
               end else if (timeout_hit) begin
                  rdata_W <= '0;
                  done_M  <= 1'b1;
                  bus_err <= 1'b1;
                  state   <= DONE;
               end else cnt <= cnt + 1'b1;
            end
            DRAIN: if (data_ok) state <= IDLE;
            DONE:  state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule
